// File: rtl/spi_sck_gen.sv
// SPI SCK generator: runtime divider, CPOL/CPHA, framed bit count, shift/sample strobes.
// Optional define SPI_SCK_GEN_RX_DLY_EN adds cfg_rx_dly to delay rev strobe and done by 0..3 cycles.
module spi_sck_gen #(
  parameter int DIV_W = 8,
  parameter int CNT_W = 6
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic             cfg_cpol,
  input  logic             cfg_cpha,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic [CNT_W-1:0] bit_num,
  input  logic             start,
  input  logic             pause,
`ifdef SPI_SCK_GEN_RX_DLY_EN
  input  logic [1:0]       cfg_rx_dly,
`endif
  output logic             busy,
  output logic             done,
  output logic             spi_sck,
  output logic             trs_ctrl_data_en,
  output logic             rev_ctrl_data_en,
  output logic [CNT_W-1:0] bit_cnt
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state;
  logic [DIV_W-1:0] hcnt;
  logic             sck_i;
  logic             cpol_l, cpha_l;
  logic [DIV_W-1:0] div_l;
  logic [CNT_W-1:0] num_l;
  logic             trs_r, rev_r, done_r;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      hcnt    <= '0;
      sck_i   <= 1'b0;
      cpol_l  <= 1'b0;
      cpha_l  <= 1'b0;
      div_l   <= '0;
      num_l   <= '0;
      busy    <= 1'b0;
      done_r  <= 1'b0;
      trs_r   <= 1'b0;
      rev_r   <= 1'b0;
      bit_cnt <= '0;
      spi_sck <= 1'b0;
    end else begin
      trs_r  <= 1'b0;
      rev_r  <= 1'b0;
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          spi_sck <= cfg_cpol;
          busy    <= 1'b0;
          bit_cnt <= '0;
          sck_i   <= 1'b0;
          hcnt    <= '0;
          // done_r high means this is the done cycle: a start here is dropped
          if (start && !done_r) begin
            cpol_l <= cfg_cpol;
            cpha_l <= cfg_cpha;
            div_l  <= cfg_div;
            num_l  <= bit_num;
            busy   <= 1'b1;
            trs_r  <= ~cfg_cpha;
            state  <= RUN;
          end
        end
        RUN: begin
          if (!pause) begin
            if (hcnt == div_l) begin
              hcnt  <= '0;
              sck_i <= ~sck_i;
              if (!sck_i) begin
                spi_sck <= ~cpol_l;
                if (cpha_l) trs_r <= 1'b1;
                else        rev_r <= 1'b1;
              end else begin
                spi_sck <= cpol_l;
                if (cpha_l)                 rev_r <= 1'b1;
                else if (bit_cnt != num_l)  trs_r <= 1'b1;
                if (bit_cnt == num_l) begin
                  state   <= IDLE;
                  busy    <= 1'b0;
                  done_r  <= 1'b1;
                  bit_cnt <= '0;
                end else begin
                  bit_cnt <= bit_cnt + 1'b1;
                end
              end
            end else begin
              hcnt <= hcnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign trs_ctrl_data_en = trs_r;

`ifdef SPI_SCK_GEN_RX_DLY_EN
  logic [2:0] rev_line, done_line;
  logic [3:0] rev_tap, done_tap;

  assign rev_tap  = {rev_line, rev_r};
  assign done_tap = {done_line, done_r};

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      rev_line  <= '0;
      done_line <= '0;
    end else begin
      rev_line  <= rev_tap[2:0];
      done_line <= done_tap[2:0];
    end
  end

  assign rev_ctrl_data_en = rev_tap[cfg_rx_dly];
  assign done             = done_tap[cfg_rx_dly];
`else
  assign rev_ctrl_data_en = rev_r;
  assign done             = done_r;
`endif

endmodule

// File: tb/tb_spi_sck_gen.sv
// Randomized + directed bench for spi_sck_gen against a tick-count behavioural model.
module tb_spi_sck_gen;

  logic       clock = 1'b0;
  logic       rst_n = 1'b0;
  logic       cfg_cpol = 1'b0, cfg_cpha = 1'b0;
  logic [7:0] cfg_div = '0;
  logic [5:0] bit_num = '0;
  logic       start = 1'b0, pause = 1'b0;
  logic       busy, done, spi_sck, trs, rev;
  logic [5:0] bit_cnt;

  int vectors = 0;
  int miscompares = 0;

  spi_sck_gen #(.DIV_W(8), .CNT_W(6)) dut (
    .clock(clock), .rst_n(rst_n), .cfg_cpol(cfg_cpol), .cfg_cpha(cfg_cpha),
    .cfg_div(cfg_div), .bit_num(bit_num), .start(start), .pause(pause),
    .busy(busy), .done(done), .spi_sck(spi_sck),
    .trs_ctrl_data_en(trs), .rev_ctrl_data_en(rev), .bit_cnt(bit_cnt)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Model: a frame is 2*(n+1)*(d+1) unpaused ticks; edge e happens at tick e*(d+1).
  bit m_busy = 0, m_done = 0, m_trs = 0, m_rev = 0, m_sck = 0;
  int m_cnt = 0;
  int t = 0, md = 0, mn = 0;
  bit mcpol = 0, mcpha = 0;

  always @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 0; m_done = 0; m_trs = 0; m_rev = 0; m_sck = 0; m_cnt = 0;
    end else begin
      m_trs = 0; m_rev = 0;
      if (!m_busy) begin
        bit pd;
        pd = m_done; m_done = 0; m_sck = cfg_cpol; m_cnt = 0;
        if (start && !pd) begin
          m_busy = 1; t = 0; md = int'(cfg_div); mn = int'(bit_num);
          mcpol = cfg_cpol; mcpha = cfg_cpha;
          m_trs = !cfg_cpha;
        end
      end else begin
        m_done = 0;
        if (!pause) begin
          t++;
          if (t % (md + 1) == 0) begin
            int e, b;
            e = t / (md + 1);
            b = (e - 1) / 2;
            if (e % 2 == 1) begin
              if (mcpha) m_trs = 1; else m_rev = 1;
            end else begin
              if (mcpha) m_rev = 1; else if (b != mn) m_trs = 1;
            end
            if (e == 2 * (mn + 1)) begin m_busy = 0; m_done = 1; end
          end
        end
        if (m_busy) begin
          int ec;
          ec = t / (md + 1);
          m_sck = (ec % 2 == 1) ? !mcpol : mcpol;
          m_cnt = ec / 2;
        end else begin
          m_sck = mcpol; m_cnt = 0;
        end
      end
    end
  end

  always @(posedge clock) begin
    #1;
    chk("busy", busy, m_busy);
    chk("done", done, m_done);
    chk("spi_sck", spi_sck, m_sck);
    chk("trs", trs, m_trs);
    chk("rev", rev, m_rev);
    chk("bit_cnt", bit_cnt, m_cnt);
  end

  task automatic count_done(input int cycles, output int nd);
    nd = 0;
    for (int k = 0; k < cycles; k++) begin
      @(posedge clock); #1;
      if (done) nd++;
    end
  endtask

  task automatic run_frame(input string tag, input bit cp, input bit ph, input int dv, input int nb,
                           input int pat, input int plen, input bit poke,
                           input int exp_cyc, input int exp_t, input int exp_r);
    int cyc, nt, nr, nd;
    bit got;
    cfg_cpol = cp; cfg_cpha = ph; cfg_div = 8'(dv); bit_num = 6'(nb);
    @(negedge clock);
    start = 1'b1;
    cyc = 0; nt = 0; nr = 0; got = 0;
    for (int k = 1; k <= 3000 && !got; k++) begin
      @(posedge clock); #1;
      cyc = k;
      start = 1'b0;
      if (k == pat) pause = 1'b1;
      if (k == pat + plen) pause = 1'b0;
      if (poke && k == 10) start = 1'b1;
      if (poke && k == 12) cfg_div = 8'(dv + 3);
      if (trs) nt++;
      if (rev) nr++;
      if (done) begin
        got = 1;
        if (poke) start = 1'b1;
      end
    end
    pause = 1'b0;
    if (!got) begin
      miscompares++;
      $display("FAIL %s timeout: no done within bound", tag);
    end
    chk({tag, " cycles"}, cyc, exp_cyc);
    chk({tag, " trs count"}, nt, exp_t);
    chk({tag, " rev count"}, nr, exp_r);
    @(posedge clock); #1;
    start = 1'b0;
    chk({tag, " idle after done"}, busy, 0);
    count_done(40, nd);
    chk({tag, " extra done"}, nd, 0);
  endtask

  initial begin
    int nd;
    bit hit;
    repeat (3) @(negedge clock);
    chk("reset busy", busy, 0);
    chk("reset spi_sck", spi_sck, 0);
    chk("reset bit_cnt", bit_cnt, 0);
    cfg_cpol = 1'b1;
    rst_n = 1'b1;
    @(posedge clock); #1;
    chk("spi_sck after release", spi_sck, 1);

    run_frame("mode0", 0, 0, 1, 7, 0, 0, 0, 33, 8, 8);
    run_frame("mode3", 1, 1, 0, 3, 0, 0, 0, 9, 4, 4);
    run_frame("pause", 0, 0, 2, 7, 23, 5, 0, 54, 8, 8);
    run_frame("handshake", 0, 0, 1, 7, 0, 0, 1, 33, 8, 8);
    run_frame("maxframe", 0, 1, 0, 63, 0, 0, 0, 129, 64, 64);

    // Reset abort during bit 2
    cfg_cpol = 1'b0; cfg_cpha = 1'b0; cfg_div = 8'd1; bit_num = 6'd7;
    @(negedge clock); start = 1'b1;
    @(posedge clock); #1; start = 1'b0;
    hit = 0;
    for (int k = 0; k < 100 && !hit; k++) begin
      @(posedge clock); #1;
      if (bit_cnt == 6'd2) hit = 1;
    end
    chk("abort reached bit 2", hit, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort busy", busy, 0);
    chk("abort trs", trs, 0);
    chk("abort rev", rev, 0);
    chk("abort bit_cnt", bit_cnt, 0);
    chk("abort spi_sck", spi_sck, 0);
    @(negedge clock);
    cfg_cpol = 1'b1;
    rst_n = 1'b1;
    @(posedge clock); #1;
    chk("abort sck reload", spi_sck, 1);
    count_done(30, nd);
    chk("abort no done", nd, 0);

    // Randomized traffic, model checks every cycle
    for (int k = 0; k < 4000; k++) begin
      @(negedge clock);
      cfg_cpol = 1'($urandom);
      cfg_cpha = 1'($urandom);
      cfg_div  = 8'($urandom_range(0, 3));
      bit_num  = ($urandom % 16 == 0) ? 6'd63 : 6'($urandom_range(0, 7));
      start    = ($urandom % 6 == 0);
      pause    = ($urandom % 8 == 0);
    end
    @(negedge clock);
    start = 1'b0; pause = 1'b0;
    for (int k = 0; k < 700 && busy; k++) @(negedge clock);
    chk("random drained", busy, 0);
    repeat (2) @(negedge clock);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/spi_sck_gen.md
Name: spi_sck_gen

Overview:
- Parametrised successor to the fixed double-rate SPI clock generator.
- Generates SPI SCK from the system clock using a runtime-programmable divider and runtime CPOL/CPHA mode.
- Frames a programmable number of bits per transfer with a start/busy/done handshake.
- Emits single-cycle shift (trs) and sample (rev) strobes for the shift-register datapath in the spi_master.

Parameters:
DIV_W, 8, width of half-period divider config; SCK half period = cfg_div+1 clock cycles
CNT_W, 6, width of bit counter; frame length = bit_num+1 bits (1..2^CNT_W)

Ports:
clock  in  1  system clock
rst_n  in  1  asynchronous active-low reset
cfg_cpol  in  1  SCK idle level
cfg_cpha  in  1  0: sample on leading edge; 1: shift on leading edge
cfg_div  in  DIV_W  half-period minus one
bit_num  in  CNT_W  frame bits minus one
start  in  1  single-cycle frame request, honoured only when idle
pause  in  1  freeze SCK and all strobes while high
busy  out  1  frame in progress
done  out  1  single-cycle pulse after last edge
spi_sck  out  1  SPI serial clock (registered)
trs_ctrl_data_en  out  1  single-cycle strobe: drive next MOSI bit
rev_ctrl_data_en  out  1  single-cycle strobe: capture MISO bit
bit_cnt  out  CNT_W  index of current bit, 0 = first

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE.
  - busy, done, trs, rev, bit_cnt, hcnt, sck_i all 0.
  - spi_sck resets to 0.
  - First clock after release: spi_sck loads cfg_cpol.
- Reset mid-frame aborts the frame. No done pulse is issued.
- Internal registers: hcnt[DIV_W], sck_i (phase, 0 = idle), edge counter.
- Output relation: spi_sck = sck_i XOR cpol_l. cpol_l, cpha_l, div_l and num_l are latched at start and held for the whole frame.
- IDLE:
  - busy=0; spi_sck tracks cfg_cpol each cycle.
  - On start=1: latch config, busy=1 next cycle, hcnt=0, go to RUN.
  - If cfg_cpha=0, trs pulses in the cycle after start so that bit 0 is set up before the first edge.
- RUN:
  - Each cycle with pause=0: hcnt increments. When hcnt==div_l, hcnt clears and sck_i toggles; this is an edge event.
  - Leading edge (sck_i 0->1): CPHA=0 gives rev; CPHA=1 gives trs.
  - Trailing edge (sck_i 1->0):
    - CPHA=0: trs, except on the last bit.
    - CPHA=1: rev.
    - bit_cnt increments after the trailing edge of every bit except the last.
  - Strobes assert in the same cycle the new spi_sck value appears on the output.
  - After the trailing edge of bit num_l: go to IDLE, done=1 for one cycle, busy=0 in that same cycle, sck back at idle level.
- Edge and timing counts:
  - Edges per frame = 2*(num_l+1).
  - Frame length, start to done = 2*(num_l+1)*(div_l+1) cycles, plus paused cycles.
- pause=1:
  - hcnt, sck_i and bit_cnt hold.
  - trs/rev forced 0, including a strobe that would fire in that cycle; the edge is deferred, not lost.
  - pause in IDLE has no effect.
- Boundary conditions:
  - start while busy: ignored.
  - start in the same cycle as done: ignored; a new frame needs start in IDLE.
  - Config inputs changing mid-frame: ignored.
  - cfg_div=0 gives SCK = clock/2, the fastest rate; one edge per cycle.
  - bit_num=2^CNT_W-1 gives the maximum frame. bit_cnt never wraps within a frame.

Optional Feature:
- Macro: SPI_SCK_GEN_RX_DLY_EN.
- When defined:
  - Adds input cfg_rx_dly[1:0].
  - rev_ctrl_data_en is delayed by cfg_rx_dly clock cycles (0..3) through a shift line, compensating pad/flash round-trip delay.
  - done is delayed by the same amount, so the last sample precedes or coincides with done.
  - The shift line clears on reset.
- When undefined: no extra port, and rev is not delayed (dly=0).

Test Plan:
- Mode 0: cpol=0, cpha=0, div=1, bit_num=7, start → 8 SCK periods of 4 clocks each; 8 rev strobes on rising edges; 8 trs strobes (first 1 cycle after start, then 7 on falling edges); done at cycle 33 after start; spi_sck ends at 0.
- Mode 3: cpol=1, cpha=1, div=0, bit_num=3 → SCK idles 1, toggles every clock; trs on falling SCK, rev on rising SCK, 4 each; done 9 cycles after start.
- Pause: mode 0, div=2, bit_num=7; pause high 5 cycles mid-bit 3 → SCK and bit_cnt frozen, no strobes during pause; frame 5 cycles longer (48+1+5); strobe counts still 8/8.
- Handshake: second start pulsed while busy and in the done cycle → ignored, exactly one done. cfg_div changed mid-frame → period unchanged.
- Reset abort: rst_n low during bit 2 → busy, strobes and bit_cnt go to 0 immediately; spi_sck=0, then cfg_cpol after release; no done.
- With SPI_SCK_GEN_RX_DLY_EN, cfg_rx_dly=2 → each rev strobe 2 cycles after its SCK edge; done shifted by 2.
